// File: rtl/pet_kbd_pkg.sv
// Shared types and constants for the PET keyboard matrix scanner.
package pet_kbd_pkg;

  localparam int          KBD_ROWS      = 10;
  localparam logic [16:0] KBD_BASE_ADDR = 17'hE800;
  localparam logic [7:0]  KBD_IDLE_BYTE = 8'hFF;

  typedef logic [7:0] kbd_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_COMMIT,
    ST_WRITE,
    ST_NEXT
  } kbd_scan_state_t;

endpackage

// File: rtl/kbd_row_debouncer.sv
// Combinational debounce step for one keyboard row; shared by all rows because
// the scanner visits them one at a time.
module kbd_row_debouncer
  import pet_kbd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = $clog2(DEBOUNCE_SCANS + 1)
) (
  input  kbd_byte_t        last_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  kbd_byte_t        committed_i,
  input  kbd_byte_t        sample_i,
  input  logic             flush_i,
  output kbd_byte_t        last_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             commit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    last_o = last_i;
    cnt_o  = cnt_i;
    if (sample_i == last_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + 1'b1;
    end else begin
      last_o = sample_i;
      cnt_o  = CNT_W'(1);
    end
    // The flush pass commits whatever was just sampled, changed or not.
    commit_o = flush_i || ((cnt_i == CNT_MAX) && (last_i != committed_i));
  end

endmodule

// File: rtl/kbd_matrix_scanner.sv
// PET keyboard matrix scanner: one-row-at-a-time drive, per-row debounce, one bus
// write per committed change. Define KBD_SCAN_FLUSH_EN to write every row once after reset.
module kbd_matrix_scanner
  import pet_kbd_pkg::*;
#(
  parameter int          NUM_ROWS       = KBD_ROWS,
  parameter int          SETTLE_CYCLES  = 64,
  parameter int          DEBOUNCE_SCANS = 4,
  parameter logic [16:0] BASE_ADDR      = KBD_BASE_ADDR
) (
  input  logic                clk,
  input  logic                res,
  input  logic                scan_en,
  output logic [NUM_ROWS-1:0] kbd_row_b,
  input  logic [7:0]          kbd_col_b,
  output logic                wr_req,
  input  logic                wr_ack,
  output logic [16:0]         wr_addr,
  output logic [7:0]          wr_data,
  output logic                key_any
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUM_ROWS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  kbd_scan_state_t     state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  kbd_byte_t           last_q      [NUM_ROWS];
  kbd_byte_t           last_d      [NUM_ROWS];
  logic [CNT_W-1:0]    cnt_q       [NUM_ROWS];
  logic [CNT_W-1:0]    cnt_d       [NUM_ROWS];
  kbd_byte_t           committed_q [NUM_ROWS];
  kbd_byte_t           committed_d [NUM_ROWS];
  logic [NUM_ROWS-1:0] kbd_row_b_q, kbd_row_b_d;
  logic                wr_req_q, wr_req_d;
  logic [16:0]         wr_addr_q, wr_addr_d;
  kbd_byte_t           wr_data_q, wr_data_d;
  logic                key_any_q, key_any_d;

  kbd_byte_t           db_last;
  logic [CNT_W-1:0]    db_cnt;
  logic                db_commit;
  logic                flush_active;

`ifdef KBD_SCAN_FLUSH_EN
  logic flush_q, flush_d;

  always_comb begin
    flush_d = flush_q;
    if (state_q == ST_NEXT && row_q == LAST_ROW) flush_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (res) flush_q <= 1'b1;
    else     flush_q <= flush_d;
  end

  assign flush_active = flush_q;
`else
  assign flush_active = 1'b0;
`endif

  kbd_row_debouncer #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .last_i      (last_q[row_q]),
    .cnt_i       (cnt_q[row_q]),
    .committed_i (committed_q[row_q]),
    .sample_i    (kbd_col_b),
    .flush_i     (flush_active),
    .last_o      (db_last),
    .cnt_o       (db_cnt),
    .commit_o    (db_commit)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    settle_d    = settle_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        settle_d = '0;
        if (scan_en) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                         settle_d = settle_q + 1'b1;
      end
      ST_SAMPLE: begin
        last_d[row_q] = db_last;
        cnt_d[row_q]  = db_cnt;
        state_d       = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (db_commit) begin
          committed_d[row_q] = last_q[row_q];
          wr_addr_d          = BASE_ADDR + 17'(row_q);
          wr_data_d          = last_q[row_q];
          state_d            = ST_WRITE;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WRITE: begin
        if (wr_ack) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        row_d    = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        settle_d = '0;
        state_d  = scan_en ? ST_DRIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    kbd_row_b_d = '1;
    if (state_d == ST_DRIVE || state_d == ST_SAMPLE) kbd_row_b_d[row_d] = 1'b0;
    wr_req_d = (state_d == ST_WRITE);

    key_any_d = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (committed_d[r] != KBD_IDLE_BYTE) key_any_d = 1'b1;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      settle_q    <= '0;
      kbd_row_b_q <= '1;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      wr_data_q   <= KBD_IDLE_BYTE;
      key_any_q   <= 1'b0;
      // NOTE: the per-row arrays are a handful of flops with defined reset values, not a RAM, so they are reset.
      for (int r = 0; r < NUM_ROWS; r++) begin
        last_q[r]      <= KBD_IDLE_BYTE;
        cnt_q[r]       <= '0;
        committed_q[r] <= KBD_IDLE_BYTE;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      settle_q    <= settle_d;
      kbd_row_b_q <= kbd_row_b_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      key_any_q   <= key_any_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
    end
  end

  assign kbd_row_b = kbd_row_b_q;
  assign wr_req    = wr_req_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign key_any   = key_any_q;

endmodule
